// File: rtl/seq_detect_pkg.sv
// Shared definitions for the "101" sequence detector and its word scheduler.
//   - fsm_state_t : scheduler states (IDLE, SHIFT, DONE)
//   - det_state_t : Mealy detector states (S0, S1, S2)
//   - DEF_DATA_W / DEF_CNT_W : default word and match-counter widths
package seq_detect_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // nothing useful seen
    S1 = 2'd1,  // seen "1"
    S2 = 2'd2   // seen "10"
  } det_state_t;

endpackage

// File: rtl/mealy_seq_detector.sv
// Serial "101" Mealy detector.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (state -> S0)
//   clr          : synchronous clear to S0 (has priority over en)
//   en           : advance the state on this edge
//   overlap      : 1 = after a match continue from S1, 0 = restart at S0
//   x            : serial input bit
//   y            : combinational match output (S2 and x=1)
module mealy_seq_detector
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic overlap,
  input  logic x,
  output logic y
);

  det_state_t state, next_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   state <= S0;
    else if (clr)   state <= S0;
    else if (en)    state <= next_state;
  end

  // NOTE: defaults are assigned first so no path through the case leaves an
  // output unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    y          = 1'b0;
    unique case (state)
      S0: next_state = x ? S1 : S0;
      S1: next_state = x ? S1 : S2;
      S2: begin
        if (x) begin
          y          = 1'b1;
          next_state = overlap ? S1 : S0;
        end else begin
          next_state = S0;
        end
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Word-to-bit scheduler around the serial "101" detector.
// Accepts a DATA_W-bit word (valid/ready), shifts it MSB-first into the
// detector one bit per clock, accumulates a saturating match count and a
// per-bit match mask, then offers the result (valid/ready).
// Ports:
//   clk, reset_n                     : clock, async active-low reset
//   in_valid/in_ready/in_data        : input word handshake (ready only in IDLE)
//   in_overlap                       : overlap mode, captured on accept
//   out_valid/out_ready              : result handshake (valid only in DONE)
//   out_count, out_mask              : match count, mask (bit i = match on in_data[i])
//   busy                             : SHIFT or DONE
//   ser_x, ser_y                     : detector input / match output (debug)
// Configuration macro: SEQ_CARRY_EN -- when defined the detector state is not
// cleared on accept, so patterns spanning word boundaries are detected.
module seq_detect_scheduler
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_overlap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] out_mask,
  output logic              busy,
  output logic              ser_x,
  output logic              ser_y
);

  localparam int IDX_W = $clog2(DATA_W);

  fsm_state_t        state, next_state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mask;
  logic              overlap_q;
  logic              accept;
  logic              det_clr;

  assign accept = (state == IDLE) && in_valid;

`ifdef SEQ_CARRY_EN
  assign det_clr = 1'b0;
`else
  assign det_clr = accept;
`endif

  mealy_seq_detector u_det (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (det_clr),
    .en      (state == SHIFT),
    .overlap (overlap_q),
    .x       (ser_x),
    .y       (ser_y)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid)          next_state = SHIFT;
      SHIFT:   if (bit_idx == '0)     next_state = DONE;
      DONE:    if (out_ready)         next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      bit_idx   <= '0;
      count     <= '0;
      mask      <= '0;
      overlap_q <= 1'b0;
    end else if (accept) begin
      shreg     <= in_data;
      bit_idx   <= IDX_W'(DATA_W - 1);
      count     <= '0;
      mask      <= '0;
      overlap_q <= in_overlap;
    end else if (state == SHIFT) begin
      if (ser_y) begin
        if (count != '1) count <= count + CNT_W'(1);  // saturate at all-ones
        mask[bit_idx] <= 1'b1;
      end
      shreg   <= {shreg[DATA_W-2:0], 1'b0};
      bit_idx <= bit_idx - IDX_W'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign ser_x     = (state == SHIFT) && shreg[DATA_W-1];
  assign out_count = count;
  assign out_mask  = mask;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed self-checking bench for seq_detect_scheduler (DATA_W=16, CNT_W=5).
// Expected counts and masks are hand-derived from the "101" detector rules.
module tb_seq_detect_scheduler;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_overlap;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [DATA_W-1:0] out_mask;
  logic              busy;
  logic              ser_x;
  logic              ser_y;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_detect_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_overlap (in_overlap),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_mask   (out_mask),
    .busy       (busy),
    .ser_x      (ser_x),
    .ser_y      (ser_y)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else             n_pass++;
  endtask

  // Present a word and return #1 after the accept edge.
  task automatic send(input logic [DATA_W-1:0] data, input logic ov);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_data    = data;
    in_overlap = ov;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_data    = ~data;
    in_overlap = ~ov;  // must not affect the word in flight
    check("accept_busy",  {31'd0, busy},     32'd1);
    check("accept_ready", {31'd0, in_ready}, 32'd0);
    check("ser_x_msb",    {31'd0, ser_x},    {31'd0, data[DATA_W-1]});
  endtask

  // Wait for the result, check latency and data, optionally stall, then pop it.
  task automatic expect_result(input string tag, input int exp_cnt,
                               input logic [DATA_W-1:0] exp_mask, input int hold);
    int k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, k, DATA_W);
    check({tag, "_count"}, {27'd0, out_count}, exp_cnt);
    check({tag, "_mask"},  {16'd0, out_mask},  {16'd0, exp_mask});
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 16'h0005;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, in_ready},  32'd0);
      check({tag, "_hold_count"}, {27'd0, out_count}, exp_cnt);
      check({tag, "_hold_mask"},  {16'd0, out_mask},  {16'd0, exp_mask});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_pop_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_pop_ready"}, {31'd0, in_ready},  32'd1);
    check({tag, "_pop_busy"},  {31'd0, busy},      32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_overlap = 1'b0;
    out_ready  = 1'b0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_ser_x",     {31'd0, ser_x},     32'd0);
    check("rst_count",     {27'd0, out_count}, 32'd0);
    check("rst_mask",      {16'd0, out_mask},  32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    send(16'h3654, 1'b1); expect_result("w3654_ov",  3, 16'h0414, 0);
    send(16'h3654, 1'b0); expect_result("w3654_nov", 2, 16'h0410, 0);
    send(16'hAAAA, 1'b1); expect_result("wAAAA_ov",  7, 16'h2AAA, 0);
    send(16'hAAAA, 1'b0); expect_result("wAAAA_nov", 4, 16'h2222, 0);

    // Abort mid-word: 8 bits of AAAA shifted, partial count is nonzero.
    send(16'hAAAA, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, in_ready},  32'd1);
    check("abort_busy",      {31'd0, busy},      32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_count",     {27'd0, out_count}, 32'd0);
    check("abort_mask",      {16'd0, out_mask},  32'd0);
    check("abort_ser_x",     {31'd0, ser_x},     32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    send(16'h3654, 1'b1); expect_result("post_abort", 3, 16'h0414, 0);

    send(16'hFFFF, 1'b1); expect_result("wFFFF", 0, 16'h0000, 0);
    send(16'h0000, 1'b1); expect_result("w0000", 0, 16'h0000, 5);
    // The in_valid pulses during the stall must not have started a word.
    @(posedge clk); #1;
    check("stall_ignored_busy",  {31'd0, busy},     32'd0);
    check("stall_ignored_ready", {31'd0, in_ready}, 32'd1);
    check("idle_ser_x",          {31'd0, ser_x},    32'd0);

    send(16'h0002, 1'b1); expect_result("carry_w1", 0, 16'h0000, 0);
`ifdef SEQ_CARRY_EN
    send(16'h8000, 1'b1); expect_result("carry_w2", 1, 16'h8000, 0);
`else
    send(16'h8000, 1'b1); expect_result("carry_w2", 0, 16'h0000, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
